// File: rtl/sysid_check_master.sv
// Avalon-MM read master that fetches the sysid ID and build timestamp words and
// compares them against expected values, reporting match / mismatch / timeout.
module sysid_check_master #(
    parameter logic [31:0] EXPECTED_ID    = 32'h0400_0000,
    parameter logic [31:0] EXPECTED_TS    = 32'h5453_5370,
    parameter bit          CHECK_TS       = 1'b1,
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter bit          AUTO_START     = 1'b1
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        start,
    output logic        avm_address,
    output logic        avm_read,
    input  logic [31:0] avm_readdata,
    input  logic        avm_waitrequest,
    output logic        busy,
    output logic        done,
    output logic [31:0] id_value,
    output logic [31:0] ts_value,
    output logic        match,
    output logic        timeout
);

    typedef enum logic [1:0] {StIdle, StRdId, StRdTs, StFinish} state_e;

    localparam logic [15:0] CntLast = 16'(TIMEOUT_CYCLES - 1);

    state_e      state_q, state_d;
    logic        addr_q, addr_d;
    logic        read_q, read_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        match_q, match_d;
    logic        timeout_q, timeout_d;
    logic        auto_q, auto_d;
    logic [31:0] id_q, id_d;
    logic [31:0] ts_q, ts_d;
    logic [15:0] cnt_q, cnt_d;

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        read_d    = read_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        match_d   = match_q;
        timeout_d = timeout_q;
        auto_d    = auto_q;
        id_d      = id_q;
        ts_d      = ts_q;
        cnt_d     = cnt_q;

        unique case (state_q)
            StIdle: begin
                if (start || auto_q) begin
                    state_d   = StRdId;
                    auto_d    = 1'b0;
                    match_d   = 1'b0;
                    timeout_d = 1'b0;
                    busy_d    = 1'b1;
                    read_d    = 1'b1;
                    addr_d    = 1'b0;
                    cnt_d     = '0;
                end
            end
            StRdId, StRdTs: begin
                if (!avm_waitrequest) begin
                    cnt_d = '0;
                    if (state_q == StRdId) begin
                        id_d    = avm_readdata;
                        addr_d  = 1'b1;
                        state_d = StRdTs;
                    end else begin
                        // Compare the word on the bus; ts_q has not been updated yet.
                        ts_d    = avm_readdata;
                        read_d  = 1'b0;
                        match_d = (id_q == EXPECTED_ID) &&
                                  (!CHECK_TS || (avm_readdata == EXPECTED_TS));
                        done_d  = 1'b1;
                        state_d = StFinish;
                    end
                end else if (cnt_q == CntLast) begin
                    read_d    = 1'b0;
                    timeout_d = 1'b1;
                    done_d    = 1'b1;
                    state_d   = StFinish;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            StFinish: begin
                busy_d  = 1'b0;
                addr_d  = 1'b0;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= StIdle;
            addr_q    <= 1'b0;
            read_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            match_q   <= 1'b0;
            timeout_q <= 1'b0;
            auto_q    <= AUTO_START;
            id_q      <= '0;
            ts_q      <= '0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            read_q    <= read_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            match_q   <= match_d;
            timeout_q <= timeout_d;
            auto_q    <= auto_d;
            id_q      <= id_d;
            ts_q      <= ts_d;
            cnt_q     <= cnt_d;
        end
    end

    assign avm_address = addr_q;
    assign avm_read    = read_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign match       = match_q;
    assign timeout     = timeout_q;
    assign id_value    = id_q;
    assign ts_value    = ts_q;

endmodule

// File: tb/tb_sysid_check_master.sv
// Bench for sysid_check_master: two instances (auto-start/strict-TS and
// manual/ignore-TS, both with an 8-cycle timeout) share stimulus and slave words.
module tb_sysid_check_master;

    localparam logic [31:0] EXP_ID = 32'h0400_0000;
    localparam logic [31:0] EXP_TS = 32'h5453_5370;
    localparam logic [31:0] ID_BAD = 32'h0400_0001;

    typedef struct {
        logic [31:0] id;
        logic [31:0] ts;
        logic        m;
        logic        t;
    } exp_t;

    logic        clock;
    logic        reset_n;
    logic        start;
    logic        wait_r;
    logic [31:0] id_word, ts_word;

    logic        addr_a, read_a, busy_a, done_a, match_a, timeout_a;
    logic [31:0] rd_a, id_a, ts_a;
    logic        addr_b, read_b, busy_b, done_b, match_b, timeout_b;
    logic [31:0] rd_b, id_b, ts_b;

    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t q_a[$];
    exp_t q_b[$];
    exp_t ea, eb;
    int   lat;

    assign rd_a = addr_a ? ts_word : id_word;
    assign rd_b = addr_b ? ts_word : id_word;

    sysid_check_master #(
        .EXPECTED_ID(EXP_ID), .EXPECTED_TS(EXP_TS), .CHECK_TS(1'b1),
        .TIMEOUT_CYCLES(8), .AUTO_START(1'b1)
    ) dut_a (
        .clock(clock), .reset_n(reset_n), .start(start),
        .avm_address(addr_a), .avm_read(read_a), .avm_readdata(rd_a),
        .avm_waitrequest(wait_r), .busy(busy_a), .done(done_a),
        .id_value(id_a), .ts_value(ts_a), .match(match_a), .timeout(timeout_a)
    );

    sysid_check_master #(
        .EXPECTED_ID(EXP_ID), .EXPECTED_TS(EXP_TS), .CHECK_TS(1'b0),
        .TIMEOUT_CYCLES(8), .AUTO_START(1'b0)
    ) dut_b (
        .clock(clock), .reset_n(reset_n), .start(start),
        .avm_address(addr_b), .avm_read(read_b), .avm_readdata(rd_b),
        .avm_waitrequest(wait_r), .busy(busy_b), .done(done_b),
        .id_value(id_b), .ts_value(ts_b), .match(match_b), .timeout(timeout_b)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic push_a(input logic [31:0] id, input logic [31:0] ts, input logic m,
                          input logic t);
        q_a.push_back('{id: id, ts: ts, m: m, t: t});
    endtask

    task automatic push_b(input logic [31:0] id, input logic [31:0] ts, input logic m,
                          input logic t);
        q_b.push_back('{id: id, ts: ts, m: m, t: t});
    endtask

    // Counts negedges until done_a, starting from the negedge where start was raised.
    task automatic wait_done(input int max, output int l);
        l = -1;
        for (int i = 1; i <= max; i++) begin
            @(negedge clock);
            start = 1'b0;
            if (done_a) begin
                l = i;
                break;
            end
        end
    endtask

    // Scoreboard: every done pulse pops the result expected for that sequence.
    always @(negedge clock) begin
        if (reset_n && done_a) begin
            if (q_a.size() == 0) begin
                check32("a_unexpected_done", done_a, 1'b0);
            end else begin
                ea = q_a.pop_front();
                check32("a_id_value", id_a, ea.id);
                check32("a_ts_value", ts_a, ea.ts);
                check32("a_match", match_a, ea.m);
                check32("a_timeout", timeout_a, ea.t);
            end
        end
        if (reset_n && done_b) begin
            if (q_b.size() == 0) begin
                check32("b_unexpected_done", done_b, 1'b0);
            end else begin
                eb = q_b.pop_front();
                check32("b_id_value", id_b, eb.id);
                check32("b_ts_value", ts_b, eb.ts);
                check32("b_match", match_b, eb.m);
                check32("b_timeout", timeout_b, eb.t);
            end
        end
    end

    initial begin
        reset_n = 1'b0;
        start   = 1'b0;
        wait_r  = 1'b0;
        id_word = EXP_ID;
        ts_word = EXP_TS;
        repeat (2) @(negedge clock);

        check32("rst_busy", busy_a, 1'b0);
        check32("rst_read", read_a, 1'b0);
        check32("rst_addr", addr_a, 1'b0);
        check32("rst_done", done_a, 1'b0);
        check32("rst_match", match_a, 1'b0);
        check32("rst_timeout", timeout_a, 1'b0);
        check32("rst_id", id_a, 32'h0);
        check32("rst_ts", ts_a, 32'h0);

        // Auto-launch after reset release, good image.
        push_a(EXP_ID, EXP_TS, 1'b1, 1'b0);
        reset_n = 1'b1;
        @(negedge clock);
        check32("t1_read_id", read_a, 1'b1);
        check32("t1_addr_id", addr_a, 1'b0);
        check32("t1_busy", busy_a, 1'b1);
        check32("t1_b_no_auto", busy_b, 1'b0);
        @(negedge clock);
        check32("t1_read_ts", read_a, 1'b1);
        check32("t1_addr_ts", addr_a, 1'b1);
        @(negedge clock);
        check32("t1_done", done_a, 1'b1);
        check32("t1_read_drop", read_a, 1'b0);
        @(negedge clock);
        check32("t1_done_single", done_a, 1'b0);
        check32("t1_idle_busy", busy_a, 1'b0);

        // ID mismatch; a start coinciding with done must be ignored.
        id_word = ID_BAD;
        push_a(ID_BAD, EXP_TS, 1'b0, 1'b0);
        push_b(ID_BAD, EXP_TS, 1'b0, 1'b0);
        start = 1'b1;
        wait_done(8, lat);
        check32("t2_latency", lat, 32'd3);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        check32("t2_start_on_done_a", busy_a, 1'b0);
        check32("t2_start_on_done_b", busy_b, 1'b0);
        @(negedge clock);
        check32("t2_still_idle", read_a, 1'b0);

        // Timestamp mismatch; start held high through the sequence is not queued.
        id_word = EXP_ID;
        ts_word = 32'h0000_0000;
        push_a(EXP_ID, 32'h0, 1'b0, 1'b0);
        push_b(EXP_ID, 32'h0, 1'b1, 1'b0);
        start = 1'b1;
        repeat (3) @(negedge clock);
        start = 1'b0;
        check32("t3_done", done_a, 1'b1);
        repeat (2) @(negedge clock);
        check32("t3_no_requeue_a", busy_a, 1'b0);
        check32("t3_no_requeue_b", busy_b, 1'b0);

        // Three stalled cycles on the ID read.
        ts_word = EXP_TS;
        id_word = 32'hBAD0_BAD0;
        push_a(EXP_ID, EXP_TS, 1'b1, 1'b0);
        push_b(EXP_ID, EXP_TS, 1'b1, 1'b0);
        start  = 1'b1;
        wait_r = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            start = 1'b0;
            check32("t4_stall_read", read_a, 1'b1);
            check32("t4_stall_addr", addr_a, 1'b0);
        end
        wait_r  = 1'b0;
        id_word = EXP_ID;
        @(negedge clock);
        check32("t4_addr_ts", addr_a, 1'b1);
        @(negedge clock);
        check32("t4_done", done_a, 1'b1);
        @(negedge clock);

        // TS read stuck on waitrequest: timeout after 8 stalled cycles.
        ts_word = 32'hDEAD_BEEF;
        push_a(EXP_ID, EXP_TS, 1'b0, 1'b1);
        push_b(EXP_ID, EXP_TS, 1'b0, 1'b1);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        @(negedge clock);
        wait_r = 1'b1;
        check32("t5_addr_ts", addr_a, 1'b1);
        for (int i = 3; i <= 9; i++) begin
            @(negedge clock);
            check32("t5_stall_read", read_a, 1'b1);
        end
        @(negedge clock);
        check32("t5_done", done_a, 1'b1);
        check32("t5_read_drop", read_a, 1'b0);
        wait_r = 1'b0;
        @(negedge clock);
        check32("t5_timeout_sticky", timeout_a, 1'b1);
        ts_word = EXP_TS;
        push_a(EXP_ID, EXP_TS, 1'b1, 1'b0);
        push_b(EXP_ID, EXP_TS, 1'b1, 1'b0);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        check32("t5_timeout_clear", timeout_a, 1'b0);
        check32("t5_restart_busy", busy_a, 1'b1);
        wait_done(8, lat);
        check32("t5_restart_latency", lat, 32'd2);
        @(negedge clock);

        // Reset asserted during the TS read, then auto-relaunch.
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        @(negedge clock);
        check32("t6_in_rd_ts", addr_a, 1'b1);
        #1 reset_n = 1'b0;
        #1;
        check32("t6_async_busy", busy_a, 1'b0);
        check32("t6_async_read", read_a, 1'b0);
        check32("t6_async_addr", addr_a, 1'b0);
        check32("t6_async_id", id_a, 32'h0);
        check32("t6_async_busy_b", busy_b, 1'b0);
        @(negedge clock);
        push_a(EXP_ID, EXP_TS, 1'b1, 1'b0);
        reset_n = 1'b1;
        wait_done(8, lat);
        check32("t6_rerun_latency", lat, 32'd3);
        @(negedge clock);
        check32("t6_match_held", match_a, 1'b1);
        check32("t6_b_idle", busy_b, 1'b0);

        // Reset while idle clears a sticky match immediately.
        #1 reset_n = 1'b0;
        #1;
        check32("t7_async_match", match_a, 1'b0);
        check32("t7_async_ts", ts_a, 32'h0);
        @(negedge clock);

        check32("q_a_drained", q_a.size(), 32'd0);
        check32("q_b_drained", q_b.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
